cassette_rec: RTL
=================

Name: cassette_rec

Overview:
Cassette recorder: the write-side counterpart to the cassette player. It watches the CoCo 6-bit sound DAC while the cassette motor relay is on and demodulates the CoCo FSK tape signal: one cycle per bit, ~1200 Hz = 0, ~2400 Hz = 1, LSB first. It byte-aligns on the 0x55 leader and writes decoded bytes sequentially into the cassette buffer RAM. The result is a CAS image the player can replay.

Parameters:
ADDR_W, 16, width of buffer address / length
THRESH_HI, 36, DAC level at or above which the comparator goes high
THRESH_LO, 28, DAC level at or below which the comparator goes low
PERIOD_MIN, 200, shortest valid cycle, in q_en ticks
PERIOD_SPLIT, 560, periods below this decode as 1, at or above as 0
PERIOD_MAX, 1200, longest valid cycle, in q_en ticks
GAP_TICKS, 2048, ticks without a rising edge that count as an inter-block gap

Ports:
clk  in  1  system clock (clk_sys)
COCO_RESET_N  in  1  synchronous active-low reset
q_en  in  1  one-clk strobe at the CoCo Q rate (~894.886 kHz)
motor  in  1  cassette relay (cas_relay); 1 = recording enabled
clear  in  1  one-clk pulse: rewind the buffer to address 0
dac_in  in  6  sound DAC value (cocosound)
ram_addr  out  ADDR_W  write address
ram_data  out  8  write data
ram_wr  out  1  one-clk write strobe, active high
rec_len  out  ADDR_W  number of bytes recorded (the write pointer)
synced  out  1  1 while in state BYTE
full  out  1  buffer exhausted; further bytes dropped

Behaviour:
- Reset (COCO_RESET_N=0 at a clk edge):
  - all outputs 0; state IDLE; comparator 0; period counter 0; shift register 0; bit counter 0; "first edge" flag set.
- Comparator (hysteresis), updated only on q_en ticks:
  - goes to 1 when dac_in >= THRESH_HI; goes to 0 when dac_in <= THRESH_LO; otherwise holds.
  - A rising edge is a q_en tick where the comparator changes 0->1.
- Period counter cnt:
  - increments on each q_en tick without a rising edge; saturates at GAP_TICKS.
  - On a rising edge: P = cnt+1, then cnt <- 0.
- Edge classification:
  - Start-only (no bit emitted, flag then cleared) when the first-edge flag is set.
  - Bit 1 when PERIOD_MIN <= P < PERIOD_SPLIT.
  - Bit 0 when PERIOD_SPLIT <= P <= PERIOD_MAX.
  - Otherwise a glitch: no bit, and the edge becomes the new period start.
  - Bits shift LSB-first: sh <= {bit, sh[7:1]}.
- States:
  - IDLE: motor=0. cnt held at 0, first-edge flag set. On motor=1 -> HUNT.
  - HUNT: shift each bit. If the new sh == 8'h55, emit byte 0x55, bitcnt <- 0, -> BYTE.
  - BYTE: shift each bit, bitcnt++. On the 8th bit, emit sh and set bitcnt <- 0.
  - From any state, motor=0 -> IDLE. Any partial byte is discarded; rec_len is retained.
  - In HUNT/BYTE, cnt reaching GAP_TICKS -> HUNT: partial byte discarded, first-edge flag set.
- Emit:
  - ram_wr=1 for exactly one clk, on the clk after the completing q_en tick.
  - ram_addr = rec_len before increment; ram_data = byte. rec_len increments in that same cycle.
  - ram_addr/ram_data hold until the next emit.
  - A write to address 2^ADDR_W-1 sets full. Afterwards, while full=1, no ram_wr occurs and rec_len holds. Decoding continues.
- clear:
  - rec_len <- 0, full <- 0, bitcnt <- 0, first-edge flag set.
  - State -> HUNT if motor=1, else IDLE.
  - clear has priority over a simultaneous emit; that byte is dropped.
- Reset mid-byte behaves as a full reset.

Test Plan:
- Reset -> ram_wr=0, rec_len=0, synced=0, full=0; dac_in swings 0/63 with motor=0 -> no writes.
- motor=1; one start cycle, 3x 0x55 leader, 0x3C, 0xA5 (0 = 746-tick cycle, 1 = 373-tick cycle) -> writes 0x55@0, 0x55@1, 0x55@2, 0x3C@3, 0xA5@4; rec_len=5; synced=1 after the first write.
- Mid-stream: one 150-tick and one 1400-tick cycle inserted -> no bit emitted from either; the later byte stream stays bit-aligned relative to the resumed edges.
- dac_in held at 32 (between thresholds) for 2100 ticks in BYTE -> synced=0. A new leader 0x55 + 0x3C -> writes resume at rec_len.
- motor low after 4 bits of a byte, then high, leader + 0x12 -> the partial byte is never written.
- ADDR_W=4, 17 bytes decoded -> 16 writes (addr 0..15), full=1, rec_len=0 (wrapped). Then clear -> full=0, the next byte goes to addr 0.

Source files
------------

// File: rtl/cassette_rec.sv
// cassette_rec: FSK cassette recorder.
// Watches the 6-bit sound DAC while the cassette relay is on and demodulates
// the tape signal one cycle per bit: a short cycle (~2400 Hz) is a 1 and a
// long cycle (~1200 Hz) is a 0, LSB first. The bit stream is byte-aligned on
// the 0x55 leader and each decoded byte is written sequentially into the
// cassette buffer RAM, producing a CAS image the player can replay.
//
// Ports:
//   clk           system clock
//   COCO_RESET_N  synchronous active-low reset
//   q_en          one-clk strobe at the CoCo Q rate; all timing is in these ticks
//   motor         cassette relay, 1 = recording enabled
//   clear         one-clk pulse, rewinds the buffer to address 0
//   dac_in        sound DAC value
//   ram_addr      write address (holds between writes)
//   ram_data      write data (holds between writes)
//   ram_wr        one-clk write strobe
//   rec_len       number of bytes recorded (write pointer)
//   synced        1 while byte-aligned
//   full          buffer exhausted, further bytes are dropped
module cassette_rec #(
  parameter int ADDR_W       = 16,
  parameter int THRESH_HI    = 36,
  parameter int THRESH_LO    = 28,
  parameter int PERIOD_MIN   = 200,
  parameter int PERIOD_SPLIT = 560,
  parameter int PERIOD_MAX   = 1200,
  parameter int GAP_TICKS    = 2048
) (
  input  logic              clk,
  input  logic              COCO_RESET_N,
  input  logic              q_en,
  input  logic              motor,
  input  logic              clear,
  input  logic [5:0]        dac_in,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_data,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] rec_len,
  output logic              synced,
  output logic              full
);

  // Counter is wide enough to hold GAP_TICKS and the derived period GAP_TICKS+1.
  localparam int CNT_W = $clog2(GAP_TICKS + 2);

  localparam logic [5:0]       TH_HI   = 6'(THRESH_HI);
  localparam logic [5:0]       TH_LO   = 6'(THRESH_LO);
  localparam logic [CNT_W-1:0] P_MIN   = CNT_W'(PERIOD_MIN);
  localparam logic [CNT_W-1:0] P_SPLIT = CNT_W'(PERIOD_SPLIT);
  localparam logic [CNT_W-1:0] P_MAX   = CNT_W'(PERIOD_MAX);
  localparam logic [CNT_W-1:0] GAP     = CNT_W'(GAP_TICKS);
  localparam logic [CNT_W-1:0] GAP_M1  = CNT_W'(GAP_TICKS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HUNT = 2'd1;
  localparam logic [1:0] ST_BYTE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              comp_q, comp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              first_q, first_d;
  logic [7:0]        sh_q, sh_d;
  logic [2:0]        bitcnt_q, bitcnt_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]        ram_data_q, ram_data_d;
  logic              ram_wr_q, ram_wr_d;
  logic [ADDR_W-1:0] rec_len_q, rec_len_d;
  logic              full_q, full_d;

  logic              rise;
  logic [CNT_W-1:0]  period;
  logic              is_one;
  logic              is_zero;
  logic              emit;

  // Hysteresis comparator: levels between the thresholds keep the last state,
  // so DAC noise around mid-scale cannot produce spurious edges.
  always_comb begin
    comp_d = comp_q;
    if (q_en) begin
      if (dac_in >= TH_HI) begin
        comp_d = 1'b1;
      end else if (dac_in <= TH_LO) begin
        comp_d = 1'b0;
      end
    end
  end

  assign rise    = q_en & ~comp_q & comp_d;
  assign period  = cnt_q + CNT_W'(1);
  assign is_one  = (period >= P_MIN) && (period < P_SPLIT);
  assign is_zero = (period >= P_SPLIT) && (period <= P_MAX);

  // Decoder and buffer-write control. A rising edge closes one cycle; its
  // length picks the bit. The gap check fires once, on the tick the counter
  // first reaches the saturation value, so the edge that ends a long silence
  // is still treated as a fresh period start.
  // clear is applied last so it overrides a byte completing on the same tick.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    first_d    = first_q;
    sh_d       = sh_q;
    bitcnt_d   = bitcnt_q;
    emit       = 1'b0;
    rec_len_d  = rec_len_q;
    full_d     = full_q;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    ram_wr_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d    = '0;
        first_d  = 1'b1;
        sh_d     = '0;
        bitcnt_d = '0;
        if (motor) begin
          state_d = ST_HUNT;
        end
      end
      default: begin
        if (!motor) begin
          state_d  = ST_IDLE;
          cnt_d    = '0;
          first_d  = 1'b1;
          sh_d     = '0;
          bitcnt_d = '0;
        end else if (rise) begin
          cnt_d = '0;
          if (first_q) begin
            first_d = 1'b0;
          end else if (is_one || is_zero) begin
            sh_d = {is_one, sh_q[7:1]};
            if (state_q == ST_HUNT) begin
              if (sh_d == 8'h55) begin
                emit     = 1'b1;
                bitcnt_d = '0;
                state_d  = ST_BYTE;
              end
            end else begin
              bitcnt_d = bitcnt_q + 3'd1;
              if (bitcnt_q == 3'd7) begin
                emit     = 1'b1;
                bitcnt_d = '0;
              end
            end
          end
        end else if (q_en && (cnt_q != GAP)) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == GAP_M1) begin
            state_d  = ST_HUNT;
            first_d  = 1'b1;
            sh_d     = '0;
            bitcnt_d = '0;
          end
        end
      end
    endcase

    if (clear) begin
      rec_len_d = '0;
      full_d    = 1'b0;
      bitcnt_d  = '0;
      sh_d      = '0;
      first_d   = 1'b1;
      state_d   = motor ? ST_HUNT : ST_IDLE;
    end else if (emit && !full_q) begin
      ram_wr_d   = 1'b1;
      ram_addr_d = rec_len_q;
      ram_data_d = sh_d;
      rec_len_d  = rec_len_q + ADDR_W'(1);
      if (rec_len_q == '1) begin
        full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!COCO_RESET_N) begin
      state_q    <= ST_IDLE;
      comp_q     <= 1'b0;
      cnt_q      <= '0;
      first_q    <= 1'b1;
      sh_q       <= '0;
      bitcnt_q   <= '0;
      ram_addr_q <= '0;
      ram_data_q <= '0;
      ram_wr_q   <= 1'b0;
      rec_len_q  <= '0;
      full_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      comp_q     <= comp_d;
      cnt_q      <= cnt_d;
      first_q    <= first_d;
      sh_q       <= sh_d;
      bitcnt_q   <= bitcnt_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      ram_wr_q   <= ram_wr_d;
      rec_len_q  <= rec_len_d;
      full_q     <= full_d;
    end
  end

  assign ram_addr = ram_addr_q;
  assign ram_data = ram_data_q;
  assign ram_wr   = ram_wr_q;
  assign rec_len  = rec_len_q;
  assign synced   = (state_q == ST_BYTE);
  assign full     = full_q;

endmodule
